// File: rtl/mux_arbiter_pkg.sv
// Shared defaults, channel type and round-robin pick for the two-channel FIFO arbiter.
package mux_arbiter_pkg;

  localparam int unsigned DefaultDataWidth = 4;
  localparam int unsigned DefaultFifoDepth = 4;
  localparam int unsigned DefaultPtrWidth  = $clog2(DefaultFifoDepth);

  typedef enum logic {
    Chan0 = 1'b0,
    Chan1 = 1'b1
  } chan_e;

  // On a tie the channel that was not served last wins.
  function automatic chan_e rr_pick(input logic ne0, input logic ne1, input chan_e last);
    if (ne0 && ne1) begin
      return (last == Chan0) ? Chan1 : Chan0;
    end else if (ne1) begin
      return Chan1;
    end else begin
      return Chan0;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty are distinct.
module sync_fifo
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned Width    = DefaultDataWidth,
  parameter int unsigned Depth    = DefaultFifoDepth,
  parameter int unsigned PtrWidth = DefaultPtrWidth
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PtrWidth:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth:0] rd_ptr_q, rd_ptr_d;
  logic [Width-1:0]  mem_q [Depth];
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]) &&
                   (wr_ptr_q[PtrWidth-1:0] == rd_ptr_q[PtrWidth-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[PtrWidth-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrWidth-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mux_arbiter.sv
// Two input FIFOs merged round-robin into one registered output with valid/ready handshake.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_0,
  input  logic                  valid_0,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic                  valid_1,
  output logic                  full_0,
  output logic                  full_1,
  output logic                  drop_0,
  output logic                  drop_1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  sel_out,
  input  logic                  ready_out
);

  localparam int unsigned PtrWidth = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] rdata_0, rdata_1;
  logic                  empty_0, empty_1;
  logic                  pop_0, pop_1;
  logic                  out_free, do_grant;
  chan_e                 grant;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  sel_q, sel_d;
  chan_e                 last_q, last_d;
  logic                  drop_0_q, drop_1_q;

  sync_fifo #(
    .Width    (DATA_WIDTH),
    .Depth    (FIFO_DEPTH),
    .PtrWidth (PtrWidth)
  ) u_fifo_0 (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (valid_0 && !full_0),
    .pop_i   (pop_0),
    .wdata_i (data_0),
    .rdata_o (rdata_0),
    .full_o  (full_0),
    .empty_o (empty_0)
  );

  sync_fifo #(
    .Width    (DATA_WIDTH),
    .Depth    (FIFO_DEPTH),
    .PtrWidth (PtrWidth)
  ) u_fifo_1 (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (valid_1 && !full_1),
    .pop_i   (pop_1),
    .wdata_i (data_1),
    .rdata_o (rdata_1),
    .full_o  (full_1),
    .empty_o (empty_1)
  );

  always_comb begin
    out_free = !valid_q || ready_out;
    grant    = rr_pick(!empty_0, !empty_1, last_q);
    do_grant = out_free && (!empty_0 || !empty_1);
    pop_0    = do_grant && (grant == Chan0);
    pop_1    = do_grant && (grant == Chan1);

    data_d  = data_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (do_grant) begin
      data_d  = (grant == Chan1) ? rdata_1 : rdata_0;
      valid_d = 1'b1;
      sel_d   = grant;
      last_d  = grant;
    end else if (out_free) begin
      valid_d = 1'b0;
    end
  end

  // last_q resets to channel 1 so channel 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      sel_q    <= 1'b0;
      last_q   <= Chan1;
      drop_0_q <= 1'b0;
      drop_1_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      drop_0_q <= valid_0 && full_0;
      drop_1_q <= valid_1 && full_1;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sel_out   = sel_q;
  assign drop_0    = drop_0_q;
  assign drop_1    = drop_1_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed and random checks of mux_arbiter against a queue-based behavioural model.
module tb_mux_arbiter;

  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_0, data_1, data_out;
  logic          valid_0, valid_1, ready_out;
  logic          full_0, full_1, drop_0, drop_1, valid_out, sel_out;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: per-channel queues plus the visible output register.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] m_data;
  logic          m_valid, m_sel, m_last, m_drop0, m_drop1;

  always #5 clk = ~clk;

  mux_arbiter #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_0    (data_0),
    .valid_0   (valid_0),
    .data_1    (data_1),
    .valid_1   (valid_1),
    .full_0    (full_0),
    .full_1    (full_1),
    .drop_0    (drop_0),
    .drop_1    (drop_1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .sel_out   (sel_out),
    .ready_out (ready_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_sel   = 1'b0;
    m_last  = 1'b1;
    m_drop0 = 1'b0;
    m_drop1 = 1'b0;
  endtask

  // One rising edge: all decisions use the state and inputs before the edge.
  task automatic model_edge();
    bit free, f0, f1;
    if (reset) begin
      model_reset();
      return;
    end
    free = !m_valid || ready_out;
    f0   = (q0.size() == DEPTH);
    f1   = (q1.size() == DEPTH);
    if (free) begin
      if (q0.size() > 0 && (q1.size() == 0 || m_last == 1'b1)) begin
        m_data = q0.pop_front(); m_sel = 1'b0; m_last = 1'b0; m_valid = 1'b1;
      end else if (q1.size() > 0) begin
        m_data = q1.pop_front(); m_sel = 1'b1; m_last = 1'b1; m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_drop0 = valid_0 && f0;
    m_drop1 = valid_1 && f1;
    if (valid_0 && !f0) q0.push_back(data_0);
    if (valid_1 && !f1) q1.push_back(data_1);
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s_valid", tag), valid_out, m_valid);
    chk($sformatf("%s_data", tag), data_out, m_data);
    chk($sformatf("%s_sel", tag), sel_out, m_sel);
    chk($sformatf("%s_full0", tag), full_0, q0.size() == DEPTH);
    chk($sformatf("%s_full1", tag), full_1, q1.size() == DEPTH);
    chk($sformatf("%s_drop0", tag), drop_0, m_drop0);
    chk($sformatf("%s_drop1", tag), drop_1, m_drop1);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_d[4];
    logic          exp_s[4];
    int            drops, attempts, accepted, dut_drops;

    reset = 1'b1; valid_0 = 1'b0; valid_1 = 1'b0; ready_out = 1'b0;
    data_0 = '0; data_1 = '0;
    #2;
    model_reset();
    check_all("por");

    // Single word latency.
    do_reset();
    ready_out = 1'b1; valid_0 = 1'b1; data_0 = 4'hA;
    tick();
    chk("lat_early_valid", valid_out, 1'b0);
    valid_0 = 1'b0;
    tick();
    chk("lat_valid", valid_out, 1'b1);
    chk("lat_data", data_out, 4'hA);
    chk("lat_sel", sel_out, 1'b0);

    // Round-robin order with both channels preloaded.
    do_reset();
    ready_out = 1'b0;
    valid_0 = 1'b1; data_0 = 4'd1; valid_1 = 1'b1; data_1 = 4'd9;
    tick();
    data_0 = 4'd2; data_1 = 4'd8;
    tick();
    valid_0 = 1'b0; valid_1 = 1'b0;
    tick();
    exp_d = '{4'd1, 4'd9, 4'd2, 4'd8};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr%0d_data", i), data_out, exp_d[i]);
      chk($sformatf("rr%0d_sel", i), sel_out, exp_s[i]);
      chk($sformatf("rr%0d_valid", i), valid_out, 1'b1);
      tick();
    end
    chk("rr_drain", valid_out, 1'b0);

    // Overflow of channel 0 while the output is stalled on a channel-1 word.
    do_reset();
    ready_out = 1'b0;
    valid_1 = 1'b1; data_1 = 4'd7;
    tick();
    valid_1 = 1'b0;
    tick();
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      valid_0 = 1'b1; data_0 = 4'(i + 3);
      tick();
      drops += int'(drop_0);
      if (i == 2) chk("ovf_not_full", full_0, 1'b0);
      if (i == 3) chk("ovf_full", full_0, 1'b1);
    end
    valid_0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      drops += int'(drop_0);
      chk("stall_data", data_out, 4'd7);
      chk("stall_sel", sel_out, 1'b1);
      chk("stall_full", full_0, 1'b1);
    end
    chk("ovf_drops", drops, 1);
    ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ovf_out%0d", i), data_out, 4'(i + 3));
      chk($sformatf("ovf_sel%0d", i), sel_out, 1'b0);
    end
    tick();
    chk("ovf_empty", valid_out, 1'b0);

    // Reset mid-operation with words queued and output valid.
    ready_out = 1'b0;
    valid_0 = 1'b1; data_0 = 4'd4; valid_1 = 1'b1; data_1 = 4'd5;
    tick();
    tick();
    valid_0 = 1'b0; valid_1 = 1'b0;
    chk("pre_rst_valid", valid_out, 1'b1);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_v", valid_out, 1'b0);
    tick();
    reset = 1'b0;
    ready_out = 1'b1;
    valid_0 = 1'b1; data_0 = 4'd1; valid_1 = 1'b1; data_1 = 4'd2;
    tick();
    valid_0 = 1'b0; valid_1 = 1'b0;
    tick();
    chk("post_rst_sel", sel_out, 1'b0);
    chk("post_rst_data", data_out, 4'd1);

    // Random traffic with ready toggling.
    do_reset();
    attempts = 0; accepted = 0; dut_drops = 0;
    for (int i = 0; i < 600; i++) begin
      valid_0   = 1'($urandom_range(0, 1));
      valid_1   = 1'($urandom_range(0, 1));
      data_0    = 4'($urandom);
      data_1    = 4'($urandom);
      ready_out = ($urandom_range(0, 3) != 0) ? ((i / 50) % 2 == 0) : 1'b0;
      attempts += int'(valid_0) + int'(valid_1);
      accepted += int'(valid_0 && q0.size() < DEPTH) + int'(valid_1 && q1.size() < DEPTH);
      tick();
      dut_drops += int'(drop_0) + int'(drop_1);
    end
    chk("rand_conserve", attempts, accepted + dut_drops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the width of every data port.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the entries per input FIFO; power of two, at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 data_0  input  DATA_WIDTH  SHALL carry the channel-0 write word.
REQ-006 valid_0  input  1  SHALL be the channel-0 write request.
REQ-007 data_1  input  DATA_WIDTH  SHALL carry the channel-1 write word.
REQ-008 valid_1  input  1  SHALL be the channel-1 write request.
REQ-009 full_0, full_1  output  1 each  SHALL indicate the corresponding FIFO holds FIFO_DEPTH words.
REQ-010 drop_0, drop_1  output  1 each  SHALL pulse for one cycle when a write is rejected.
REQ-011 data_out  output  DATA_WIDTH  SHALL be the granted word, registered.
REQ-012 valid_out  output  1  SHALL mark data_out as holding a word, registered.
REQ-013 sel_out  output  1  SHALL give the source channel of the current data_out, registered.
REQ-014 ready_out  input  1  SHALL be the consumer accept signal.

Function
REQ-015 Channel i SHALL write data_i into FIFO i at an edge where valid_i=1 and full_i=0.
REQ-016 A write with valid_i=1 and full_i=1 SHALL be discarded; drop_i=1 for the following cycle; FIFO contents unchanged.
REQ-017 full_i SHALL be computed from the occupancy before the edge; a same-cycle pop SHALL NOT make room for a write.
REQ-018 The output register SHALL be "free" when valid_out=0 or when valid_out=1 and ready_out=1.
REQ-019 When free, the arbiter SHALL load one word from a non-empty FIFO into data_out/sel_out, set valid_out=1 and pop that FIFO on the same edge.
REQ-020 When free and both FIFOs are empty, valid_out SHALL go to 0; data_out and sel_out SHALL hold.
REQ-021 When not free (valid_out=1 and ready_out=0), data_out, sel_out and valid_out SHALL hold and no FIFO SHALL pop.
REQ-022 If exactly one FIFO is non-empty, that FIFO SHALL be granted.
REQ-023 If both FIFOs are non-empty, the channel not granted last SHALL be granted (round-robin); last_grant SHALL update only on a grant.
REQ-024 Earliest latency: a word accepted at edge k into an empty FIFO with a free output register SHALL appear with valid_out=1 after edge k+1.
REQ-025 Words from one channel SHALL leave in arrival order; no word SHALL be duplicated or lost except by REQ-016.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra bit so full and empty are distinguishable.
REQ-027 With ready_out held at 1 and both channels backlogged, grants SHALL alternate 0,1,0,1 with valid_out continuously 1.

Reset
REQ-028 While reset=1, regardless of clk: both FIFOs empty, pointers 0, data_out=0, valid_out=0, sel_out=0, full_i=0, drop_i=0, last_grant=1 so channel 0 wins the first tie.
REQ-029 Reset asserted mid-operation SHALL discard all stored and in-flight words; no write SHALL be accepted while reset=1.
REQ-030 The first edge after reset deasserts SHALL behave as a normal operating edge.

Structure
REQ-031 Shared package SHALL hold the DATA_WIDTH and FIFO_DEPTH defaults and the derived pointer width (log2 of FIFO_DEPTH).
REQ-032 A sub-module sync_fifo (push, pop, data in/out, full, empty) SHALL be instantiated twice; arbitration and the output register SHALL reside in mux_arbiter.

Verification
REQ-033 Reset, then valid_0=1 with data_0=4'hA for one cycle, ready_out=1 -> valid_out=1, data_out=4'hA, sel_out=0 one cycle after the write edge.
REQ-034 Preload ch0 {1,2} and ch1 {9,8} with ready_out=0, then ready_out=1 -> output order 1(sel 0), 9(sel 1), 2(sel 0), 8(sel 1).
REQ-035 ready_out=0, write 5 words to ch0 -> full_0=1 after the 4th write; drop_0 pulses once; output later yields exactly the first 4 words.
REQ-036 valid_out=1 with ready_out=0 for 3 cycles -> data_out and sel_out stable; FIFO occupancy unchanged.
REQ-037 Assert reset with 3 words queued and valid_out=1 -> all outputs return to the REQ-028 values immediately; the next grant is channel 0.
REQ-038 Continuous writes on both channels with ready_out toggling randomly -> per-channel order preserved and no loss beyond counted drops (scoreboard).
